// File: rtl/phys_reg_map_restore_ctrl_pkg.sv
// Shared types for the map-table recovery controller: ROB index, register tags,
// checkpoint column and the controller state encoding.
package phys_reg_map_restore_ctrl_pkg;

    localparam int ROB_DEPTH  = 16;
    localparam int ROB_IDX_W  = $clog2(ROB_DEPTH);
    localparam int ARCH_TAG_W = 5;
    localparam int PHYS_TAG_W = 6;
    localparam int CKPT_COL_W = 2;
    localparam int PERF_W     = 16;

    typedef logic [ROB_IDX_W-1:0]  ROB_index_t;
    typedef logic [ARCH_TAG_W-1:0] arch_reg_tag_t;
    typedef logic [PHYS_TAG_W-1:0] phys_reg_tag_t;
    typedef logic [CKPT_COL_W-1:0] checkpoint_column_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHKPT = 2'd1,
        WALK  = 2'd2,
        DONE  = 2'd3
    } restore_ctrl_state_t;

    // ROB_DEPTH is a power of two, so plain modular subtraction wraps 0 -> ROB_DEPTH-1.
    function automatic ROB_index_t rob_dec(input ROB_index_t idx);
        return idx - ROB_index_t'(1);
    endfunction

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + PERF_W'(1);
    endfunction

endpackage

// File: rtl/phys_reg_map_restore_ctrl.sv
// Map-table recovery after misspeculation: one-cycle checkpoint restore, else ROB walk
// youngest->oldest reverting mappings. Optional perf counters: PHYS_REG_MAP_RESTORE_PERF_EN.
//
// state | meaning
// IDLE  | ready for a restart request
// CHKPT | checkpoint restore attempted this cycle
// WALK  | reading ROB at walk_ptr, reverting until the branch entry
// DONE  | recovery complete, restore_done pulse
module phys_reg_map_restore_ctrl
    import phys_reg_map_restore_ctrl_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    input  logic               restart_valid,
    output logic               restart_ready,
    input  ROB_index_t         restart_ROB_index,
    input  ROB_index_t         restart_tail_index,
    input  logic               restart_speculate_failed,
    input  checkpoint_column_t restart_safe_column,
    output logic               restore_checkpoint_valid,
    output logic               restore_checkpoint_speculate_failed,
    output ROB_index_t         restore_checkpoint_ROB_index,
    output checkpoint_column_t restore_checkpoint_safe_column,
    input  logic               restore_checkpoint_success,
    output ROB_index_t         rob_read_index,
    input  logic               rob_read_dest_valid,
    input  arch_reg_tag_t      rob_read_arch_reg_tag,
    input  phys_reg_tag_t      rob_read_safe_phys_reg_tag,
    input  phys_reg_tag_t      rob_read_speculated_phys_reg_tag,
    output logic               revert_valid,
    output arch_reg_tag_t      revert_dest_arch_reg_tag,
    output phys_reg_tag_t      revert_safe_dest_phys_reg_tag,
    output phys_reg_tag_t      revert_speculated_dest_phys_reg_tag,
    output logic               stall_rename,
    output logic               restore_done
`ifdef PHYS_REG_MAP_RESTORE_PERF_EN
   ,output logic [PERF_W-1:0]  restore_walk_cycles
   ,output logic [PERF_W-1:0]  restore_chkpt_hits
`endif
);

    restore_ctrl_state_t state_q, state_d;
    ROB_index_t          br_idx_q, br_idx_d;
    ROB_index_t          tail_idx_q, tail_idx_d;
    ROB_index_t          walk_ptr_q, walk_ptr_d;
    logic                spec_failed_q, spec_failed_d;
    checkpoint_column_t  column_q, column_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= IDLE;
            br_idx_q      <= '0;
            tail_idx_q    <= '0;
            walk_ptr_q    <= '0;
            spec_failed_q <= 1'b0;
            column_q      <= '0;
        end else begin
            state_q       <= state_d;
            br_idx_q      <= br_idx_d;
            tail_idx_q    <= tail_idx_d;
            walk_ptr_q    <= walk_ptr_d;
            spec_failed_q <= spec_failed_d;
            column_q      <= column_d;
        end
    end

    always_comb begin
        state_d                             = state_q;
        br_idx_d                            = br_idx_q;
        tail_idx_d                          = tail_idx_q;
        walk_ptr_d                          = walk_ptr_q;
        spec_failed_d                       = spec_failed_q;
        column_d                            = column_q;
        restart_ready                       = 1'b0;
        restore_checkpoint_valid            = 1'b0;
        revert_valid                        = 1'b0;
        revert_dest_arch_reg_tag            = '0;
        revert_safe_dest_phys_reg_tag       = '0;
        revert_speculated_dest_phys_reg_tag = '0;
        restore_done                        = 1'b0;

        unique case (state_q)
            IDLE: begin
                restart_ready = 1'b1;
                if (restart_valid) begin
                    br_idx_d      = restart_ROB_index;
                    tail_idx_d    = restart_tail_index;
                    spec_failed_d = restart_speculate_failed;
                    column_d      = restart_safe_column;
                    state_d       = CHKPT;
                end
            end
            CHKPT: begin
                restore_checkpoint_valid = 1'b1;
                if (restore_checkpoint_success) begin
                    state_d = DONE;
                end else begin
                    walk_ptr_d = rob_dec(tail_idx_q);
                    state_d    = WALK;
                end
            end
            WALK: begin
                // The branch's own mapping stays; reaching it ends the walk.
                if (walk_ptr_q == br_idx_q) begin
                    state_d = DONE;
                end else begin
                    revert_valid                        = rob_read_dest_valid;
                    revert_dest_arch_reg_tag            = rob_read_arch_reg_tag;
                    revert_safe_dest_phys_reg_tag       = rob_read_safe_phys_reg_tag;
                    revert_speculated_dest_phys_reg_tag = rob_read_speculated_phys_reg_tag;
                    walk_ptr_d                          = rob_dec(walk_ptr_q);
                end
            end
            DONE: begin
                restore_done = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_rename                        = (state_q != IDLE);
    assign rob_read_index                      = walk_ptr_q;
    assign restore_checkpoint_ROB_index        = br_idx_q;
    assign restore_checkpoint_speculate_failed = spec_failed_q;
    assign restore_checkpoint_safe_column      = column_q;

`ifdef PHYS_REG_MAP_RESTORE_PERF_EN
    logic [PERF_W-1:0] walk_cycles_q, chkpt_hits_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            walk_cycles_q <= '0;
            chkpt_hits_q  <= '0;
        end else begin
            if (state_q == WALK) begin
                walk_cycles_q <= sat_inc(walk_cycles_q);
            end
            if (state_q == CHKPT && restore_checkpoint_success) begin
                chkpt_hits_q <= sat_inc(chkpt_hits_q);
            end
        end
    end

    assign restore_walk_cycles = walk_cycles_q;
    assign restore_chkpt_hits  = chkpt_hits_q;
`endif

endmodule

// File: doc/phys_reg_map_restore_ctrl.md
Name: phys_reg_map_restore_ctrl

Overview:
Sequences recovery of the phys reg map table after a misspeculation. It first tries a one-cycle checkpoint restore. If no checkpoint matches, it walks the ROB from youngest to oldest and issues one revert per cycle until it reaches the mispredicted instruction. It sits in the core between the branch-resolve/restart logic, the ROB read port and phys_reg_map_table, and stalls rename while recovery is in progress.

Parameters:
ROB_DEPTH, 16, ROB entries; power of two; equals the depth of ROB_index_t.

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
restart_valid  in  1  request to recover
restart_ready  out  1  controller idle; a request is accepted only when valid && ready
restart_ROB_index  in  ROB_index_t  index of the mispredicted instruction
restart_tail_index  in  ROB_index_t  ROB tail (one past the youngest entry)
restart_speculate_failed  in  1  passed through to the checkpoint restore
restart_safe_column  in  checkpoint_column_t  passed through to the checkpoint restore
restore_checkpoint_valid  out  1  to map table
restore_checkpoint_speculate_failed  out  1  to map table
restore_checkpoint_ROB_index  out  ROB_index_t  to map table
restore_checkpoint_safe_column  out  checkpoint_column_t  to map table
restore_checkpoint_success  in  1  from map table, combinational in the same cycle
rob_read_index  out  ROB_index_t  ROB read address
rob_read_dest_valid  in  1  entry writes a register, combinational
rob_read_arch_reg_tag  in  arch_reg_tag_t  entry dest arch reg
rob_read_safe_phys_reg_tag  in  phys_reg_tag_t  previous mapping
rob_read_speculated_phys_reg_tag  in  phys_reg_tag_t  renamed mapping
revert_valid  out  1  to map table
revert_dest_arch_reg_tag  out  arch_reg_tag_t  to map table
revert_safe_dest_phys_reg_tag  out  phys_reg_tag_t  to map table
revert_speculated_dest_phys_reg_tag  out  phys_reg_tag_t  to map table
stall_rename  out  1  high whenever state != IDLE
restore_done  out  1  one-cycle pulse when recovery completes

Behaviour:
- States: IDLE, CHKPT, WALK, DONE. State registers plus latched fields br_idx, tail_idx, spec_failed, column, walk_ptr.
- Reset: state=IDLE and all latched fields 0.
  - Outputs at reset: restart_ready=1, all valids 0, restore_done=0, stall_rename=0, rob_read_index=0, data outputs 0.
- IDLE:
  - restart_ready=1.
  - On restart_valid: latch all restart_* fields, go to CHKPT.
  - No outputs are asserted in the accept cycle.
- CHKPT (exactly 1 cycle):
  - restore_checkpoint_valid=1, driven with the latched br_idx, spec_failed and column.
  - If restore_checkpoint_success=1: go to DONE.
  - Otherwise: walk_ptr <= tail_idx-1 (mod ROB_DEPTH), go to WALK.
- WALK:
  - rob_read_index=walk_ptr.
  - If walk_ptr==br_idx: no revert; go to DONE. The branch's own mapping is kept.
  - Otherwise: revert_valid=rob_read_dest_valid, with the three tags forwarded combinationally from the ROB read.
  - walk_ptr decrements by 1 each cycle and wraps from 0 to ROB_DEPTH-1.
- DONE (1 cycle): restore_done=1, stall_rename=1; then go to IDLE.
- Latency:
  - Checkpoint hit: accept + 2 cycles to restore_done.
  - Miss: accept + 1 + (N+1) + 1 cycles, where N = (tail_idx-1-br_idx) mod ROB_DEPTH.
- Empty walk: when tail_idx-1==br_idx, WALK lasts 1 cycle with no reverts.
- restart_valid while busy: ignored, not queued (restart_ready=0).
- Never asserts restore_checkpoint_valid and revert_valid in the same cycle.
- Reset mid-walk: returns to IDLE asynchronously; no further reverts are issued.

Optional Feature:
PHYS_REG_MAP_RESTORE_PERF_EN
- Defined:
  - Adds output restore_walk_cycles (16 bits), a saturating count of all cycles spent in WALK since reset.
  - Adds output restore_chkpt_hits (16 bits), a saturating count of checkpoint-hit recoveries.
  - Both reset to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- core_types_pkg: ROB_index_t, arch_reg_tag_t, phys_reg_tag_t, checkpoint_column_t, and a new restore_ctrl_state_t enum {IDLE, CHKPT, WALK, DONE}.
- No sub-module required. The perf counters can be a small sat_counter instance if one already exists.

Test Plan:
- Reset: nRST=0 mid-sim → restart_ready=1, stall_rename=0, every valid 0, restore_done=0.
- Checkpoint hit: accept br=5, tail=9; success=1 in CHKPT → restore_checkpoint_valid for 1 cycle with ROB_index=5; restore_done 2 cycles after accept; zero reverts.
- Checkpoint miss, walk: br=3, tail=7; dest_valid=1 for indices 6 and 4, 0 for index 5 → rob_read_index sequence 6, 5, 4, 3; revert_valid sequence 1, 0, 1, 0 with tags matching the ROB stub; restore_done the following cycle.
- Wrap-around: br=14, tail=2, ROB_DEPTH=16, all dest_valid=1 → reverts at indices 1, 0, 15; stops at 14.
- Empty walk plus busy request: br=8, tail=9 → WALK lasts 1 cycle with no revert. A restart_valid pulsed during WALK is ignored and restart_ready stays 0 until IDLE.
- Reset mid-walk: assert nRST=0 after 2 reverts of a 6-entry walk → immediate IDLE, revert_valid=0, no restore_done.
